// File: rtl/ffa_addsub_serial.sv
// Limb-serial modular add/subtract over prime P: one LIMB-wide primary adder plus a lagging correction adder.
// Optional operand range flag (range_err_o) is built only when FFA_RANGE_CHK_EN is defined.
module ffa_addsub_serial #(
  parameter int NBITS = 255,
  parameter int LIMB = 64,
  parameter logic [NBITS-1:0] P = {NBITS{1'b1}} - NBITS'(18)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [NBITS-1:0] a_i,
  input  logic [NBITS-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [NBITS-1:0] out_o
`ifdef FFA_RANGE_CHK_EN
  ,
  output logic             range_err_o
`endif
);

  localparam int NLIMBS = (NBITS + LIMB) / LIMB;
  localparam int W = NLIMBS * LIMB;
  localparam int KW = $clog2(NLIMBS + 1);
  localparam logic [W-1:0] PEXT = {{(W-NBITS){1'b0}}, P};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     s_q, s_d, corr_q, corr_d;
  logic             cPrim_q, cPrim_d, cCorr_q, cCorr_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [NBITS-1:0] out_q, out_d;
  logic [LIMB:0]    primRes, corrRes;
  logic [LIMB-1:0]  pLimb, sTop;
  logic [KW-1:0]    cIdx;
  logic             useCorr;

  // Primary stage consumes the low limb of the shifting operands; the correction stage
  // works on the limb the primary stage produced last cycle, which sits at the top of s_q.
  always_comb begin
    sTop = s_q[W-1 -: LIMB];
    cIdx = k_q - KW'(1);
    pLimb = '0;
    for (int i = 0; i < NLIMBS; i++) begin
      if (cIdx == KW'(i)) pLimb = PEXT[i*LIMB +: LIMB];
    end
    if (op_q) begin
      primRes = {1'b0, a_q[LIMB-1:0]} - {1'b0, b_q[LIMB-1:0]} - {{LIMB{1'b0}}, cPrim_q};
      corrRes = {1'b0, sTop} + {1'b0, pLimb} + {{LIMB{1'b0}}, cCorr_q};
    end else begin
      primRes = {1'b0, a_q[LIMB-1:0]} + {1'b0, b_q[LIMB-1:0]} + {{LIMB{1'b0}}, cPrim_q};
      corrRes = {1'b0, sTop} - {1'b0, pLimb} - {{LIMB{1'b0}}, cCorr_q};
    end
    useCorr = op_q ? cPrim_q : ~cCorr_q;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    corr_d  = corr_q;
    cPrim_d = cPrim_q;
    cCorr_d = cCorr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          k_d     = '0;
          op_d    = op_i;
          a_d     = {{(W-NBITS){1'b0}}, a_i};
          b_d     = {{(W-NBITS){1'b0}}, b_i};
          s_d     = '0;
          corr_d  = '0;
          cPrim_d = 1'b0;
          cCorr_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (k_q < KW'(NLIMBS)) begin
          s_d     = {primRes[LIMB-1:0], s_q[W-1:LIMB]};
          cPrim_d = primRes[LIMB];
          a_d     = a_q >> LIMB;
          b_d     = b_q >> LIMB;
        end
        if (k_q != '0) begin
          corr_d  = {corrRes[LIMB-1:0], corr_q[W-1:LIMB]};
          cCorr_d = corrRes[LIMB];
        end
        if (k_q == KW'(NLIMBS)) state_d = S_FIN;
        else k_d = k_q + KW'(1);
      end
      S_FIN: begin
        out_d   = useCorr ? corr_q[NBITS-1:0] : s_q[NBITS-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      corr_q  <= '0;
      cPrim_q <= 1'b0;
      cCorr_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      corr_q  <= corr_d;
      cPrim_q <= cPrim_d;
      cCorr_q <= cCorr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

`ifdef FFA_RANGE_CHK_EN
  logic rangeErr_q, rangeErr_d;

  always_comb begin
    rangeErr_d = rangeErr_q;
    if (state_q == S_IDLE && start_i) rangeErr_d = (a_i >= P) || (b_i >= P);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rangeErr_q <= 1'b0;
    else     rangeErr_q <= rangeErr_d;
  end

  assign range_err_o = rangeErr_q;
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign out_o  = out_q;

endmodule

// File: tb/tb_ffa_addsub_serial.sv
// Scoreboard bench for ffa_addsub_serial: driver pushes expected results, a negedge monitor pops and compares.
// Expected values come from plain modular arithmetic over P; range checks are built with FFA_RANGE_CHK_EN.
`timescale 1ns/1ps
module tb_ffa_addsub_serial;

  localparam int NBITS = 255;
  localparam logic [NBITS-1:0] P = {NBITS{1'b1}} - NBITS'(18);
  localparam int LATENCY = 6;

  typedef struct {
    logic [NBITS-1:0] out;
    int               acc;
    bit               chk;
  } exp_t;

  logic             clk, rst, start, op, busy, done;
  logic [NBITS-1:0] aIn, bIn, result;
`ifdef FFA_RANGE_CHK_EN
  logic             rangeErr;
`endif

  exp_t sbQ[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  bit   prevDone = 0;

  ffa_addsub_serial dut (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .op_i(op),
    .a_i(aIn),
    .b_i(bIn),
    .busy_o(busy),
    .done_o(done),
    .out_o(result)
`ifdef FFA_RANGE_CHK_EN
    ,
    .range_err_o(rangeErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(string name, logic [NBITS-1:0] act, logic [NBITS-1:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  // Reference: modular sum/difference computed directly in NBITS+1 bits.
  function automatic logic [NBITS-1:0] refModel(bit o, logic [NBITS-1:0] x, logic [NBITS-1:0] y);
    logic [NBITS:0] t;
    if (!o) begin
      t = {1'b0, x} + {1'b0, y};
      if (t >= {1'b0, P}) t = t - {1'b0, P};
    end else if (x >= y) begin
      t = {1'b0, x} - {1'b0, y};
    end else begin
      t = {1'b0, x} + {1'b0, P} - {1'b0, y};
    end
    return t[NBITS-1:0];
  endfunction

  function automatic logic [NBITS-1:0] randElem();
    logic [255:0]     r;
    logic [NBITS-1:0] x;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    x = r[NBITS-1:0];
    if (x >= P) x = x - P;
    case ($urandom_range(0, 15))
      0: x = '0;
      1: x = NBITS'(1);
      2: x = P - NBITS'(1);
      3: x = P - NBITS'(2);
      default: ;
    endcase
    return x;
  endfunction

  task automatic waitDrain();
    for (int i = 0; i < 40 && sbQ.size() != 0; i++) @(negedge clk);
    if (sbQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drainTimeout: got %0d pending results, required 0", sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic applyStimulus(bit o, logic [NBITS-1:0] x, logic [NBITS-1:0] y,
                               logic [NBITS-1:0] expv, bit chk);
    exp_t e;
    @(negedge clk);
    op = o;
    aIn = x;
    bIn = y;
    start = 1'b1;
    e.out = expv;
    e.acc = cyc + 1;
    e.chk = chk;
    sbQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
    waitDrain();
  endtask

  // Monitor: every done pops one expected result and checks value, latency and pulse shape.
  always @(negedge clk) begin
    if (rst) begin
      prevDone = 0;
    end else begin
      if (prevDone) checkOutput("donePulseWidth", {{(NBITS-1){1'b0}}, done}, '0);
      prevDone = done;
      if (done) begin
        checkOutput("busyInDone", {{(NBITS-1){1'b0}}, busy}, '0);
        if (sbQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedDone: got done=1 with out %h, required no done", result);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          if (e.chk) checkOutput("result", result, e.out);
          checkOutput("latency", NBITS'(cyc - e.acc), NBITS'(LATENCY));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int c0;
    logic [NBITS-1:0] x, y;
    bit o;
    rst = 1'b1;
    start = 1'b0;
    op = 1'b0;
    aIn = '0;
    bIn = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", {{(NBITS-1){1'b0}}, busy}, '0);
    checkOutput("resetDone", {{(NBITS-1){1'b0}}, done}, '0);
    checkOutput("resetOut", result, '0);
`ifdef FFA_RANGE_CHK_EN
    checkOutput("resetRangeErr", {{(NBITS-1){1'b0}}, rangeErr}, '0);
`endif
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, NBITS'(1), NBITS'(2), NBITS'(3), 1'b1);
    applyStimulus(1'b0, P - NBITS'(1), NBITS'(1), '0, 1'b1);
    applyStimulus(1'b0, P - NBITS'(1), P - NBITS'(1), P - NBITS'(2), 1'b1);
    applyStimulus(1'b1, NBITS'(5), NBITS'(3), NBITS'(2), 1'b1);
    applyStimulus(1'b1, NBITS'(3), NBITS'(5), P - NBITS'(2), 1'b1);
    applyStimulus(1'b1, '0, '0, '0, 1'b1);

    // Extra start pulses during RUN must be dropped without queueing.
    @(negedge clk);
    op = 1'b0; aIn = NBITS'(1000); bIn = NBITS'(2000); start = 1'b1;
    e.out = NBITS'(3000); e.acc = cyc + 1; e.chk = 1'b1;
    sbQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = 1'b1; aIn = NBITS'(77); bIn = NBITS'(11); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = 1'b0; aIn = NBITS'(500); bIn = NBITS'(600); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrain();
    repeat (12) @(negedge clk);

    // Held start: back-to-back accepts one throughput period apart, operands swapped after accept.
    @(negedge clk);
    c0 = cyc;
    op = 1'b0; aIn = NBITS'(40); bIn = NBITS'(2); start = 1'b1;
    e.out = NBITS'(42); e.acc = c0 + 1; e.chk = 1'b1;
    sbQ.push_back(e);
    @(negedge clk);
    op = 1'b1; aIn = NBITS'(2); bIn = NBITS'(9);
    e.out = P - NBITS'(7); e.acc = c0 + 8; e.chk = 1'b1;
    sbQ.push_back(e);
    while (cyc < c0 + 8) @(negedge clk);
    start = 1'b0;
    waitDrain();

    // Reset in the middle of RUN aborts without a done.
    @(negedge clk);
    op = 1'b0; aIn = NBITS'(100); bIn = NBITS'(200); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abortBusy", {{(NBITS-1){1'b0}}, busy}, '0);
    checkOutput("abortDone", {{(NBITS-1){1'b0}}, done}, '0);
    checkOutput("abortOut", result, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    applyStimulus(1'b0, NBITS'(7), NBITS'(8), NBITS'(15), 1'b1);

`ifdef FFA_RANGE_CHK_EN
    applyStimulus(1'b0, P, '0, '0, 1'b0);
    checkOutput("rangeErrHigh", {{(NBITS-1){1'b0}}, rangeErr}, NBITS'(1));
    applyStimulus(1'b0, P - NBITS'(1), '0, P - NBITS'(1), 1'b1);
    checkOutput("rangeErrLow", {{(NBITS-1){1'b0}}, rangeErr}, '0);
`endif

    for (int n = 0; n < 2000; n++) begin
      x = randElem();
      y = randElem();
      o = 1'($urandom_range(0, 1));
      applyStimulus(o, x, y, refModel(o, x, y), 1'b1);
    end
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
